// File: rtl/en_shiftreg_led.sv
// Enabled register bank: parallel load, bidirectional shift, autonomous LSB-first serializer.
// Latency: every output is registered, 1 cycle. No backpressure; en_i=0 freezes all state.
// Optional per-bit status LEDs on q_o and busy_o when LED_EN is defined.
module en_shiftreg_led #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             start_i,
    input  logic             ser_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             ser_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_ser, w_ser_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    // The bit that falls off each end of the concatenation is the serial output.
    logic [WIDTH:0]   w_cat_l, w_cat_r;
    assign w_cat_l = {r_q, ser_i};
    assign w_cat_r = {ser_i, r_q};

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_ser_nxt   = r_ser;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        if (en_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        w_q_nxt     = d_i;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_SHIFT;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        case (mode_i)
                            2'b01: w_q_nxt = d_i;
                            2'b10: begin
                                w_q_nxt   = w_cat_l[WIDTH-1:0];
                                w_ser_nxt = w_cat_l[WIDTH];
                            end
                            2'b11: begin
                                w_q_nxt   = w_cat_r[WIDTH:1];
                                w_ser_nxt = w_cat_r[0];
                            end
                            default: ;
                        endcase
                    end
                end
                ST_SHIFT: begin
                    w_q_nxt   = w_cat_r[WIDTH:1];
                    w_ser_nxt = w_cat_r[0];
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_q     <= RST_VAL;
            r_cnt   <= '0;
            r_ser   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ser   <= w_ser_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign q_o    = r_q;
    assign ser_o  = r_ser;
    assign busy_o = r_busy;
    assign done_o = r_done;

`ifdef LED_EN
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_led
        Led_Res_0603 u_led (.led_i(r_q[gi]));
    end
    Led_Res_0603 u_led_busy (.led_i(r_busy));
`else
`endif

endmodule

// File: tb/tb_en_shiftreg_led.sv
// Bench for en_shiftreg_led: directed vector table, multi-cycle sequences, WIDTH=1 case,
// and randomized stimulus against a countdown-based reference model.
module tb_en_shiftreg_led;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       rst, en, start, ser;
    logic [1:0] mode;
    logic [7:0] d;
    logic [7:0] q_o;
    logic       ser_o, busy_o, done_o;

    // WIDTH=1 instance
    logic       rst1, en1, start1, ser1;
    logic [1:0] mode1;
    logic [0:0] d1;
    logic [0:0] q1_o;
    logic       ser1_o, busy1_o, done1_o;

    int checks   = 0;
    int failures = 0;

    en_shiftreg_led #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .start_i(start),
        .ser_i(ser), .d_i(d), .q_o(q_o), .ser_o(ser_o), .busy_o(busy_o), .done_o(done_o)
    );

    en_shiftreg_led #(.WIDTH(1), .RST_VAL(1'b0)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .en_i(en1), .mode_i(mode1), .start_i(start1),
        .ser_i(ser1), .d_i(d1), .q_o(q1_o), .ser_o(ser1_o), .busy_o(busy1_o), .done_o(done1_o)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic       start;
        logic       ser;
        logic [7:0] d;
        logic [7:0] q;
        logic       so;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[20];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Reference model state: shifts remaining replaces any counter/state encoding
    int mq, mser, mbusy, mdone, left;

    initial begin
        int n;
        logic seen;
        logic [7:0] exp_ser;

        rst = 1; en = 0; mode = 0; start = 0; ser = 0; d = 0;
        rst1 = 1; en1 = 0; mode1 = 0; start1 = 0; ser1 = 0; d1 = 0;

        //            rst en mode  st ser d      q     so busy done
        vecs[0]  = '{1, 0, 2'b00, 0, 0, 8'h00, 8'hA5, 0, 0, 0};
        vecs[1]  = '{1, 1, 2'b01, 1, 1, 8'hFF, 8'hA5, 0, 0, 0};
        vecs[2]  = '{0, 1, 2'b01, 0, 0, 8'h3C, 8'h3C, 0, 0, 0};
        vecs[3]  = '{0, 1, 2'b10, 0, 1, 8'h00, 8'h79, 0, 0, 0};
        vecs[4]  = '{0, 1, 2'b10, 0, 1, 8'h00, 8'hF3, 0, 0, 0};
        vecs[5]  = '{0, 1, 2'b01, 0, 0, 8'h3C, 8'h3C, 0, 0, 0};
        vecs[6]  = '{0, 1, 2'b00, 1, 0, 8'h96, 8'h96, 0, 1, 0};
        vecs[7]  = '{0, 1, 2'b01, 0, 0, 8'hFF, 8'h4B, 0, 1, 0};
        vecs[8]  = '{0, 1, 2'b10, 1, 0, 8'hFF, 8'h25, 1, 1, 0};
        vecs[9]  = '{0, 1, 2'b00, 0, 0, 8'h00, 8'h12, 1, 1, 0};
        vecs[10] = '{0, 1, 2'b00, 0, 0, 8'h00, 8'h09, 0, 1, 0};
        vecs[11] = '{0, 1, 2'b00, 0, 0, 8'h00, 8'h04, 1, 1, 0};
        vecs[12] = '{0, 1, 2'b00, 0, 0, 8'h00, 8'h02, 0, 1, 0};
        vecs[13] = '{0, 1, 2'b00, 0, 0, 8'h00, 8'h01, 0, 1, 0};
        vecs[14] = '{0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 1, 0, 1};
        vecs[15] = '{0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 1, 0, 0};
        vecs[16] = '{0, 0, 2'b01, 0, 0, 8'hFF, 8'h00, 1, 0, 0};
        vecs[17] = '{0, 1, 2'b11, 0, 1, 8'h00, 8'h80, 0, 0, 0};
        vecs[18] = '{0, 1, 2'b11, 0, 0, 8'h00, 8'h40, 0, 0, 0};
        vecs[19] = '{0, 1, 2'b10, 0, 0, 8'h00, 8'h80, 0, 0, 0};

        for (int i = 0; i < 20; i++) begin
            rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
            start = vecs[i].start; ser = vecs[i].ser; d = vecs[i].d;
            if (i == 2) rst1 = 0;
            step;
            chk($sformatf("vec%0d_q", i), q_o, vecs[i].q);
            chk($sformatf("vec%0d_ser", i), {7'd0, ser_o}, {7'd0, vecs[i].so});
            chk($sformatf("vec%0d_busy", i), {7'd0, busy_o}, {7'd0, vecs[i].busy});
            chk($sformatf("vec%0d_done", i), {7'd0, done_o}, {7'd0, vecs[i].done});
        end

        // Stall for 3 cycles after shift 4
        en = 1; mode = 0; ser = 0; start = 1; d = 8'h96;
        step;
        start = 0;
        repeat (4) step;
        chk("stall_pre_q", q_o, 8'h09);
        for (int i = 0; i < 3; i++) begin
            en = 0;
            step;
            chk("stall_q", q_o, 8'h09);
            chk("stall_ser", {7'd0, ser_o}, 8'd0);
            chk("stall_busy", {7'd0, busy_o}, 8'd1);
            chk("stall_done", {7'd0, done_o}, 8'd0);
        end
        en = 1;
        exp_ser = 8'b1001_0000;
        for (int k = 0; k < 4; k++) begin
            step;
            chk("resume_ser", {7'd0, ser_o}, {7'd0, exp_ser[7-k]});
            chk("resume_done", {7'd0, done_o}, {7'd0, (k == 3)});
        end
        chk("resume_final_q", q_o, 8'h00);
        en = 0;
        step;
        chk("done_no_stretch", {7'd0, done_o}, 8'd0);

        // Reset after shift 5 aborts the run
        en = 1; start = 1; d = 8'h96;
        step;
        start = 0;
        repeat (5) step;
        chk("abort_pre_q", q_o, 8'h04);
        rst = 1;
        step;
        rst = 0;
        chk("abort_q", q_o, 8'hA5);
        chk("abort_busy", {7'd0, busy_o}, 8'd0);
        chk("abort_ser", {7'd0, ser_o}, 8'd0);
        seen = done_o;
        repeat (10) begin
            step;
            seen = seen | done_o;
        end
        chk("abort_no_done", {7'd0, seen}, 8'd0);
        start = 1; d = 8'h96;
        step;
        start = 0;
        n = 0;
        while (!done_o && n < 20) begin
            step;
            n++;
        end
        chk("rerun_shifts", 8'(n), 8'd8);

        // start held high: new run begins the cycle after done
        start = 1; d = 8'h5A;
        step;
        repeat (8) step;
        chk("b2b_done", {7'd0, done_o}, 8'd1);
        chk("b2b_busy_gap", {7'd0, busy_o}, 8'd0);
        step;
        chk("b2b_restart_busy", {7'd0, busy_o}, 8'd1);
        chk("b2b_restart_q", q_o, 8'h5A);
        start = 0;
        n = 0;
        while (busy_o && n < 20) begin
            step;
            n++;
        end
        chk("b2b_second_run", 8'(n), 8'd8);

        // WIDTH=1 serializer
        en1 = 1; start1 = 1; d1 = 1'b1; ser1 = 0;
        step;
        start1 = 0;
        chk("w1_busy", {7'd0, busy1_o}, 8'd1);
        chk("w1_q_load", {7'd0, q1_o}, 8'd1);
        step;
        chk("w1_ser", {7'd0, ser1_o}, 8'd1);
        chk("w1_q", {7'd0, q1_o}, 8'd0);
        chk("w1_busy_end", {7'd0, busy1_o}, 8'd0);
        chk("w1_done", {7'd0, done1_o}, 8'd1);
        step;
        chk("w1_done_once", {7'd0, done1_o}, 8'd0);

        // Randomized run against reference model
        rst = 1;
        step;
        mq = 'hA5; mser = 0; mbusy = 0; mdone = 0; left = 0;
        rst = 0;
        for (int c = 0; c < 2000; c++) begin
            rst   = ($urandom_range(0, 63) == 0);
            en    = ($urandom_range(0, 3) != 0);
            mode  = 2'($urandom_range(0, 3));
            start = ($urandom_range(0, 7) == 0);
            ser   = 1'($urandom_range(0, 1));
            d     = 8'($urandom);
            if (rst) begin
                mq = 'hA5; mser = 0; mbusy = 0; mdone = 0; left = 0;
            end else if (!en) begin
                mdone = 0;
            end else if (left > 0) begin
                mser  = mq % 2;
                mq    = mq / 2 + (ser ? 128 : 0);
                left  = left - 1;
                mbusy = (left > 0);
                mdone = (left == 0);
            end else begin
                mdone = 0;
                if (start) begin
                    mq = d; left = 8; mbusy = 1;
                end else if (mode == 2'b01) begin
                    mq = d;
                end else if (mode == 2'b10) begin
                    mser = mq / 128;
                    mq   = (mq * 2) % 256 + ser;
                end else if (mode == 2'b11) begin
                    mser = mq % 2;
                    mq   = mq / 2 + (ser ? 128 : 0);
                end
            end
            step;
            chk("rnd_q", q_o, 8'(mq));
            chk("rnd_ser", {7'd0, ser_o}, 8'(mser));
            chk("rnd_busy", {7'd0, busy_o}, 8'(mbusy));
            chk("rnd_done", {7'd0, done_o}, 8'(mdone));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
